// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, imem req/ack, fetch FIFO, IF_ID register; IFETCH_PERF_EN adds bubble/fetch counters
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stallIn,
  input  logic        redirectEn,
  input  logic [31:0] redirectPC,
  output logic [31:0] inst,
  output logic [31:0] instPC,
  output logic        resetOut
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] bubbleCnt,
  output logic [31:0] fetchCnt
`endif
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, drop_addr;
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;

  logic ack_ok, accept, fifo_empty, pop, bypass, push;

  // an ack only counts while a request is actually presented
  assign ack_ok     = imemAck & imemReq;
  assign accept     = (state == FETCH) & ack_ok & ~redirectEn;
  assign fifo_empty = (count == '0);
  assign pop        = ~redirectEn & ~stallIn & ~fifo_empty;
  // an arriving word goes straight to IF_ID when nothing is queued ahead of it
  assign bypass     = accept & ~stallIn & fifo_empty;
  assign push       = accept & ~bypass;

  assign imemReq  = (state == FETCH) || (state == DROP);
  assign imemAddr = (state == DROP) ? drop_addr : pc;

  // FIFO occupancy after this cycle's push/pop (redirect empties it)
  always_comb begin
    count_nxt = count;
    if (redirectEn) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // next-state logic for the request FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (redirectEn) begin
          state_nxt = ack_ok ? FETCH : DROP;
        end else if (count_nxt == CNT_FULL) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (redirectEn || (count < CNT_FULL)) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // once the stale request completes there is nothing left to drop,
        // even if another redirect lands in the same cycle
        if (ack_ok) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC and the address of a request abandoned by a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else if (redirectEn) begin
      pc <= redirectPC & 32'hFFFF_FFFC;
      if (state == FETCH && !ack_ok) begin
        drop_addr <= pc;
      end
    end else if (accept) begin
      pc <= pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || redirectEn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
    end
  end

  // FIFO storage, written without reset
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= pc;
      buf_data[wr_ptr] <= imemData;
    end
  end

  // IF_ID output register
  always_ff @(posedge clk) begin
    if (rst) begin
      inst     <= NOP_INST;
      instPC   <= 32'h0;
      resetOut <= 1'b1;
    end else if (redirectEn) begin
      inst     <= NOP_INST;
      resetOut <= 1'b1;
    end else if (!stallIn) begin
      if (pop) begin
        inst     <= buf_data[rd_ptr];
        instPC   <= buf_pc[rd_ptr];
        resetOut <= 1'b0;
      end else if (bypass) begin
        inst     <= imemData;
        instPC   <= pc;
        resetOut <= 1'b0;
      end else begin
        inst     <= NOP_INST;
        resetOut <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic bubble_load;
  assign bubble_load = redirectEn | (~stallIn & ~pop & ~bypass);

  // bubble loads into IF_ID and accepted fetches
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt <= 32'h0;
      fetchCnt  <= 32'h0;
    end else begin
      if (bubble_load) begin
        bubbleCnt <= bubbleCnt + 32'd1;
      end
      if (accept) begin
        fetchCnt <= fetchCnt + 32'd1;
      end
    end
  end
`else
  // counters are not built
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized bench for inst_fetch against a queue-based fetch model
module tb_inst_fetch;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        stallIn = 1'b0;
  logic        redirectEn = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic [31:0] inst;
  logic [31:0] instPC;
  logic        resetOut;
`ifdef IFETCH_PERF_EN
  logic [31:0] bubbleCnt;
  logic [31:0] fetchCnt;
`endif

  inst_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .stallIn(stallIn), .redirectEn(redirectEn), .redirectPC(redirectPC),
    .inst(inst), .instPC(instPC), .resetOut(resetOut)
`ifdef IFETCH_PERF_EN
    , .bubbleCnt(bubbleCnt), .fetchCnt(fetchCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: pending words in arrival order, the word held by IF_ID, the fetch PC
  logic [63:0] q[$];
  bit          m_ok = 0;
  bit          m_valid;
  logic [31:0] m_inst, m_ipc, m_pc;
  bit          m_live, m_discard;
  logic [31:0] m_live_addr;
  logic [31:0] m_bub, m_fcnt;
  int          m_issued = 0;
  int          mem_wait = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F00;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (!m_ok) return;
    check32("resetOut", {31'b0, resetOut}, {31'b0, !m_valid});
    check32("inst", inst, m_valid ? m_inst : NOP);
    if (m_valid) check32("instPC", instPC, m_ipc);
    if (m_live) begin
      check32("req_held", {31'b0, imemReq}, 32'd1);
      check32("addr_held", imemAddr, m_live_addr);
    end else if (imemReq === 1'b1) begin
      check32("addr_new", imemAddr, m_pc);
      check32("req_room", {31'b0, (q.size() < DEPTH)}, 32'd1);
    end
`ifdef IFETCH_PERF_EN
    check32("bubbleCnt", bubbleCnt, m_bub);
    check32("fetchCnt", fetchCnt, m_fcnt);
`endif
  endtask

  task automatic tick(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                      input int lat_min, input int lat_max, input int stray_pct);
    bit          req_b;
    logic [31:0] addr_now;
    bit          ack;
    logic [31:0] data;
    bit          push;
    logic [63:0] w;
    req_b    = (imemReq === 1'b1);
    addr_now = imemAddr;
    ack      = 0;
    if (req_b) begin
      if (!m_live) mem_wait = $urandom_range(lat_max, lat_min);
      ack = (mem_wait == 0);
      if (!ack) mem_wait--;
      data = mem_word(addr_now);
    end else begin
      ack  = ($urandom_range(99, 0) < stray_pct);
      data = $urandom;
    end
    rst = r; stallIn = st; redirectEn = rd; redirectPC = rpc;
    imemAck = ack; imemData = data;

    if (r) begin
      q.delete();
      m_ok = 1; m_valid = 0; m_pc = RPC; m_live = 0; m_discard = 0;
      m_bub = 0; m_fcnt = 0;
    end else if (rd) begin
      q.delete();
      m_valid = 0; m_bub++;
      m_pc = rpc & 32'hFFFF_FFFC;
      if (req_b && !ack) begin
        m_live = 1; m_live_addr = addr_now; m_discard = 1;
      end else begin
        m_live = 0; m_discard = 0;
      end
    end else begin
      push = 0;
      if (req_b && ack) begin
        if (m_discard) m_discard = 0;
        else begin
          push = 1; m_pc = m_pc + 32'd4; m_fcnt++;
        end
      end
      if (st) begin
        if (push) q.push_back({addr_now, data});
      end else if (q.size() > 0) begin
        w = q.pop_front();
        m_valid = 1; m_ipc = w[63:32]; m_inst = w[31:0]; m_issued++;
        if (push) q.push_back({addr_now, data});
      end else if (push) begin
        m_valid = 1; m_ipc = addr_now; m_inst = data; m_issued++;
      end else begin
        m_valid = 0; m_bub++;
      end
      m_live = req_b && !ack;
      if (m_live) m_live_addr = addr_now;
    end

    @(posedge clk);
    #1;
    compare_all();
  endtask

  int stall_pct[4] = '{0, 30, 60, 10};
  int redir_pct[4] = '{0, 5, 10, 2};
  int latmx[4]     = '{0, 3, 2, 1};
  int stray[4]     = '{0, 20, 20, 50};

  initial begin
    int issued0;
    logic [31:0] tgt;

    // reset values
    tick(1, 0, 0, 0, 0, 0, 0);
    check32("rst_req", {31'b0, imemReq}, 32'd0);
    check32("rst_resetOut", {31'b0, resetOut}, 32'd1);
    check32("rst_inst", inst, NOP);
    check32("rst_instPC", instPC, 32'h0);

    // continuous ack across the address wrap
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("first_req", {31'b0, imemReq}, 32'd1);
    check32("first_addr", imemAddr, 32'hFFFF_FFF8);
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("w0_valid", {31'b0, resetOut}, 32'd0);
    check32("w0_pc", instPC, 32'hFFFF_FFF8);
    check32("w0_inst", inst, mem_word(32'hFFFF_FFF8));
    check32("addr1", imemAddr, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("w1_pc", instPC, 32'hFFFF_FFFC);
    check32("addr_wrap", imemAddr, 32'h0000_0000);
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("w2_pc", instPC, 32'h0000_0000);
    check32("addr3", imemAddr, 32'h0000_0004);

    // redirect coincident with ack while stalled
    tick(0, 1, 1, 32'h0000_0103, 0, 0, 0);
    check32("rd_bubble", {31'b0, resetOut}, 32'd1);
    check32("rd_inst", inst, NOP);
    check32("rd_addr", imemAddr, 32'h0000_0100);
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("rd_word_pc", instPC, 32'h0000_0100);
    check32("rd_word_valid", {31'b0, resetOut}, 32'd0);

    // redirect while a 3-cycle request to 0x104 is outstanding
    tick(0, 0, 0, 0, 3, 3, 0);
    tick(0, 0, 1, 32'h0000_0203, 3, 3, 0);
    check32("drop_addr", imemAddr, 32'h0000_0104);
    tick(0, 0, 0, 0, 3, 3, 0);
    check32("drop_hold", imemAddr, 32'h0000_0104);
    tick(0, 0, 0, 0, 3, 3, 0);
    check32("drop_done_addr", imemAddr, 32'h0000_0200);
    check32("drop_bubble", {31'b0, resetOut}, 32'd1);
    tick(0, 0, 0, 0, 0, 0, 0);
    check32("after_drop_pc", instPC, 32'h0000_0200);
`ifdef IFETCH_PERF_EN
    check32("perf_fetch_lit", fetchCnt, 32'd5);
    check32("perf_bubble_lit", bubbleCnt, 32'd6);
`endif

    // randomized phases
    issued0 = 0;
    for (int p = 0; p < 4; p++) begin
      if (p == 1) issued0 = m_issued;
      for (int i = 0; i < 2000; i++) begin
        tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        tick((p != 0) && ($urandom_range(999, 0) < 3),
             $urandom_range(99, 0) < stall_pct[p],
             $urandom_range(99, 0) < redir_pct[p],
             tgt, 0, latmx[p], stray[p]);
      end
    end
    check32("throughput", {31'b0, (issued0 > 1900)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
